jk_exc_encoder: RTL and testbench
=================================

JK_EXC_ENCODER -- requirements
Module: jk_exc_encoder

Interface
REQ-001 Parameter WIDTH, default 8, number of JK flip-flops driven (one j/k pair per bit).
REQ-002 Parameter DEPTH, default 4, target FIFO entries (power of two, at least 2).
REQ-003 Port clock, input, 1: sole clock; all logic on posedge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port tgt_valid, input, 1: tgt_data holds a desired next Q word.
REQ-006 Port tgt_ready, output, 1: FIFO can accept a word this cycle.
REQ-007 Port tgt_data, input, WIDTH: desired flip-flop bank state.
REQ-008 Port mode, input, 1: 0 = SET/RESET for changes, 1 = TOGGLE for changes.
REQ-009 Port resync, input, 1: one-cycle pulse forcing the Q model to sync_val.
REQ-010 Port sync_val, input, WIDTH: value loaded on resync.
REQ-011 Port cmd_valid, output, 1: j/k hold a valid command word.
REQ-012 Port cmd_ready, input, 1: downstream consumes the command this cycle.
REQ-013 Port j, output, WIDTH: J inputs for the flip-flop bank.
REQ-014 Port k, output, WIDTH: K inputs for the flip-flop bank.
REQ-015 Port q_model, output, WIDTH: encoder's tracked bank state.
REQ-016 Port flip_count, output, 16: saturating count of bits commanded to change.

Function
REQ-017 Push when tgt_valid and tgt_ready; tgt_ready is the inverse of FIFO-full, independent of same-cycle pop.
REQ-018 Per-bit {j,k} codes: HOLD=00, RESET=01, SET=10, TOGGLE=11.
REQ-019 Mode 0, per bit: 0->0 HOLD, 0->1 SET, 1->0 RESET, 1->1 HOLD; mode 1: every changing bit is TOGGLE, others HOLD.
REQ-020 mode is sampled in the pop cycle only; changing mode never alters a held command.
REQ-021 FSM has two states: EMPTY (cmd_valid=0) and PRESENT (cmd_valid=1).
REQ-022 Pop occurs when FIFO non-empty, resync=0, and (state EMPTY, or state PRESENT with cmd_ready=1).
REQ-023 On pop: j/k register the encoding of head versus q_model; q_model<=head; state->PRESENT.
REQ-024 PRESENT with cmd_ready=1 and no pop: state->EMPTY, and j and k are set to all-zero.
REQ-025 j, k and cmd_valid stay stable while cmd_valid=1 and cmd_ready=0.
REQ-026 Latency: word pushed into an empty FIFO with output EMPTY at cycle N gives cmd_valid=1 at cycle N+2; back-to-back accepted commands sustain one per cycle.
REQ-027 On pop, flip_count increases by popcount(head XOR q_model) and saturates at 16'hFFFF.
REQ-028 resync=1: q_model<=sync_val; pop is suppressed that cycle; a held command and FIFO contents are unaffected; pushes still allowed.
REQ-029 Push into a full FIFO is refused with no side effects; pop from an empty FIFO never occurs.
REQ-030 FIFO pointers wrap modulo DEPTH; simultaneous push and pop when not full keeps the occupancy constant.

Reset
REQ-031 On reset: FIFO empty, tgt_ready=1, state EMPTY, cmd_valid=0, j=0, k=0, q_model=0, flip_count=0.
REQ-032 Reset overrides push, pop and resync in the same cycle; a command held mid-handshake is discarded.

Structure
REQ-033 Package jk_pkg holds the four 2-bit code constants (HOLD/RESET/SET/TOGGLE), the mode encoding, and the FSM state type.
REQ-034 FIFO is sub-module jk_fifo (parameterised WIDTH, DEPTH; synchronous reset; full/empty flags).

Verification
REQ-035 Reset, mode 0, cmd_ready=1, push 8'hA5 -> two cycles later cmd_valid=1, j=8'hA5, k=8'h00, q_model=8'hA5, flip_count=4.
REQ-036 Then push 8'h5A in mode 1 -> j=8'hFF, k=8'hFF, flip_count=12; push 8'h5A again -> j=0, k=0, count unchanged.
REQ-037 cmd_ready=0, push 5 words back-to-back -> tgt_ready=0 after the 5th accept (4 in FIFO, 1 held); held j/k remain stable; release -> 5 commands in order, one per cycle.
REQ-038 Command held, resync with sync_val=8'hFF, then push 8'h0F in mode 0 -> command j=0, k=8'hF0.
REQ-039 Preload flip_count near saturation (e.g. 16'hFFFC) via repeated full toggles, then push a word with 8 bit changes -> flip_count=16'hFFFF and stays there.
REQ-040 Assert reset while cmd_valid=1 and FIFO holds 3 words -> next cycle all outputs at their reset values; no stale command appears afterward.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared encodings for the JK excitation encoder: per-bit {j,k} codes,
// the mode select values, and the output-stage state type.
package jk_pkg;

  localparam logic [1:0] CODE_HOLD   = 2'b00;
  localparam logic [1:0] CODE_RESET  = 2'b01;
  localparam logic [1:0] CODE_SET    = 2'b10;
  localparam logic [1:0] CODE_TOGGLE = 2'b11;

  localparam logic MODE_SETRESET = 1'b0;
  localparam logic MODE_TOGGLE   = 1'b1;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PRESENT = 1'b1
  } jk_state_e;

  // Excitation for one flip-flop moving from cur to nxt.
  function automatic logic [1:0] encode_bit(input logic md, input logic cur, input logic nxt);
    logic [1:0] code;
    code = CODE_HOLD;
    if (cur != nxt) begin
      if (md == MODE_TOGGLE) code = CODE_TOGGLE;
      else                   code = nxt ? CODE_SET : CODE_RESET;
    end
    return code;
  endfunction

endpackage

// File: rtl/jk_fifo.sv
// Target-word FIFO: power-of-two depth, extra pointer bit distinguishes
// full from empty. Push is refused when full, pop ignored when empty.
module jk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jk_exc_encoder.sv
// Converts a stream of desired flip-flop bank states into J/K excitation
// commands, tracking the bank state internally and counting commanded flips.
module jk_exc_encoder
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             mode,
  input  logic             resync,
  input  logic [WIDTH-1:0] sync_val,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_model,
  output logic [15:0]      flip_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready and its payload holds until taken.

  logic             fifo_full, fifo_empty, pop;
  logic [WIDTH-1:0] head, diff;
  logic [16:0]      flip_sum;

  jk_state_e        state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d, q_model_q, q_model_d;
  logic [15:0]      flip_count_q, flip_count_d;

  jk_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tgt_valid),
    .wdata (tgt_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tgt_ready  = !fifo_full;
  assign pop        = !fifo_empty && !resync && ((state_q == ST_EMPTY) || cmd_ready);
  assign cmd_valid  = (state_q == ST_PRESENT);
  assign j          = j_q;
  assign k          = k_q;
  assign q_model    = q_model_q;
  assign flip_count = flip_count_q;

  always_comb begin
    diff     = head ^ q_model_q;
    flip_sum = {1'b0, flip_count_q};
    for (int i = 0; i < WIDTH; i++) flip_sum = flip_sum + 17'(diff[i]);
  end

  always_comb begin
    state_d      = state_q;
    j_d          = j_q;
    k_d          = k_q;
    q_model_d    = q_model_q;
    flip_count_d = flip_count_q;
    if (pop) begin
      for (int i = 0; i < WIDTH; i++) {j_d[i], k_d[i]} = encode_bit(mode, q_model_q[i], head[i]);
      q_model_d    = head;
      flip_count_d = flip_sum[16] ? 16'hFFFF : flip_sum[15:0];
      state_d      = ST_PRESENT;
    end else if (state_q == ST_PRESENT && cmd_ready) begin
      j_d     = '0;
      k_d     = '0;
      state_d = ST_EMPTY;
    end
    // Resync and pop are mutually exclusive, so this never races a head load.
    if (resync) q_model_d = sync_val;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      j_q          <= '0;
      k_q          <= '0;
      q_model_q    <= '0;
      flip_count_q <= '0;
    end else begin
      state_q      <= state_d;
      j_q          <= j_d;
      k_q          <= k_d;
      q_model_q    <= q_model_d;
      flip_count_q <= flip_count_d;
    end
  end

endmodule

// File: tb/tb_jk_exc_encoder.sv
// Directed scoreboard bench for jk_exc_encoder.
module tb_jk_exc_encoder;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset, tgt_valid, mode, resync, cmd_ready;
  logic [W-1:0] tgt_data, sync_val;
  logic         tgt_ready, cmd_valid;
  logic [W-1:0] j, k, q_model;
  logic [15:0]  flip_count;

  typedef struct packed {
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    logic [15:0]  cnt;
    logic         chk_q;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           tests_run = 0;
  int           tests_failed = 0;
  logic [W-1:0] q_ref;
  int           cnt_ref;

  jk_exc_encoder #(.WIDTH(W), .DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_data   (tgt_data),
    .mode       (mode),
    .resync     (resync),
    .sync_val   (sync_val),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .j          (j),
    .k          (k),
    .q_model    (q_model),
    .flip_count (flip_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    exp_q.delete();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    q_ref   = '0;
    cnt_ref = 0;
  endtask

  // reference model: expected command for the next word in push order
  task automatic model_push(input logic [W-1:0] d, input logic chk);
    exp_t         e;
    int           pc;
    logic [W-1:0] diff;
    diff = d ^ q_ref;
    pc = 0;
    for (int i = 0; i < W; i++) pc += int'(diff[i]);
    if (mode) begin
      e.j = diff;
      e.k = diff;
    end else begin
      e.j = ~q_ref & d;
      e.k = q_ref & ~d;
    end
    cnt_ref = (cnt_ref + pc > 65535) ? 65535 : cnt_ref + pc;
    e.cnt   = cnt_ref[15:0];
    e.q     = d;
    e.chk_q = chk;
    exp_q.push_back(e);
    q_ref = d;
  endtask

  // driver
  task automatic push_word(input logic [W-1:0] d, input logic chk = 1'b1);
    int guard;
    guard = 0;
    tgt_data  = d;
    tgt_valid = 1'b1;
    @(negedge clock);
    while (!tgt_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!tgt_ready) check("push_timeout", 32'(tgt_ready), 32'd1);
    else model_push(d, chk);
    @(posedge clock);
    #1;
    tgt_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clock);
      g++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    tick(1);
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_cmd: got j=%h k=%h, required no command", j, k);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_j", 32'(j), 32'(mon_e.j));
        check("cmd_k", 32'(k), 32'(mon_e.k));
        check("cmd_cnt", 32'(flip_count), 32'(mon_e.cnt));
        if (mon_e.chk_q) check("cmd_q", 32'(q_model), 32'(mon_e.q));
      end
    end
  end

  initial begin
    #1_000_000;
    tests_run++;
    tests_failed++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    reset = 1'b1; tgt_valid = 1'b0; tgt_data = '0; mode = 1'b0;
    resync = 1'b0; sync_val = '0; cmd_ready = 1'b1;
    do_reset();

    // reset state
    @(negedge clock);
    check("rst_tgt_ready", 32'(tgt_ready), 32'd1);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_j", 32'(j), 32'd0);
    check("rst_k", 32'(k), 32'd0);
    check("rst_q", 32'(q_model), 32'd0);
    check("rst_cnt", 32'(flip_count), 32'd0);
    tick(1);

    // mode 0 first word and latency
    mode = 1'b0;
    push_word(8'hA5);
    @(negedge clock);
    check("lat_n1_valid", 32'(cmd_valid), 32'd0);
    @(negedge clock);
    check("lat_n2_valid", 32'(cmd_valid), 32'd1);
    check("a5_j", 32'(j), 32'hA5);
    check("a5_k", 32'(k), 32'h00);
    wait_drain("drain_a5");
    check("a5_cnt", 32'(flip_count), 32'd4);
    check("a5_q", 32'(q_model), 32'hA5);

    // mode 1 toggles, then a no-change word
    mode = 1'b1;
    push_word(8'h5A);
    wait_drain("drain_5a_1");
    check("5a_cnt", 32'(flip_count), 32'd12);
    push_word(8'h5A);
    wait_drain("drain_5a_2");
    check("5a_again_cnt", 32'(flip_count), 32'd12);
    mode = 1'b0;

    // backpressure: fill FIFO behind a held command
    cmd_ready = 1'b0;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    push_word(8'h55);
    @(negedge clock);
    check("full_tgt_ready", 32'(tgt_ready), 32'd0);
    check("held_valid", 32'(cmd_valid), 32'd1);
    check("held_j", 32'(j), 32'h01);
    check("held_k", 32'(k), 32'h4A);
    tick(3);
    @(negedge clock);
    check("held_stable_j", 32'(j), 32'h01);
    check("held_stable_k", 32'(k), 32'h4A);
    check("held_stable_v", 32'(cmd_valid), 32'd1);
    tick(1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("burst_valid", 32'(cmd_valid), 32'd1);
    end
    @(negedge clock);
    check("burst_end_valid", 32'(cmd_valid), 32'd0);
    check("burst_queue", 32'(exp_q.size()), 32'd0);
    tick(1);

    // resync under a held command
    cmd_ready = 1'b0;
    push_word(8'h3C, 1'b0);
    tick(2);
    resync   = 1'b1;
    sync_val = 8'hFF;
    q_ref    = 8'hFF;
    tick(1);
    resync = 1'b0;
    @(negedge clock);
    check("resync_q", 32'(q_model), 32'hFF);
    check("resync_held_valid", 32'(cmd_valid), 32'd1);
    check("resync_held_j", 32'(j), 32'h28);
    check("resync_held_k", 32'(k), 32'h41);
    tick(1);
    push_word(8'h0F);
    cmd_ready = 1'b1;
    wait_drain("drain_resync");
    check("resync_final_q", 32'(q_model), 32'h0F);

    // saturation of flip_count
    do_reset();
    mode = 1'b1;
    cmd_ready = 1'b1;
    for (int i = 0; i < 8191; i++) push_word((i % 2 == 0) ? 8'hFF : 8'h00);
    push_word(8'h0F);
    push_word(8'hF0);
    push_word(8'h0F);
    wait_drain("drain_sat");
    check("sat_cnt", 32'(flip_count), 32'hFFFF);
    mode = 1'b0;

    // reset mid-handshake with FIFO occupied
    cmd_ready = 1'b0;
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    push_word(8'h04);
    @(negedge clock);
    check("pre_rst_valid", 32'(cmd_valid), 32'd1);
    tick(1);
    exp_q.delete();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    q_ref = '0;
    cnt_ref = 0;
    @(negedge clock);
    check("mid_rst_valid", 32'(cmd_valid), 32'd0);
    check("mid_rst_tgt_ready", 32'(tgt_ready), 32'd1);
    check("mid_rst_j", 32'(j), 32'd0);
    check("mid_rst_k", 32'(k), 32'd0);
    check("mid_rst_q", 32'(q_model), 32'd0);
    check("mid_rst_cnt", 32'(flip_count), 32'd0);
    tick(1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("post_rst_idle", 32'(cmd_valid), 32'd0);
    end
    tick(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
